btn_hold_ctrl: RTL
==================

// Module: btn_hold_ctrl
// PURPOSE
// - Debounces a raw Basys3 pushbutton and produces the hold-enable that drives the sample-hold flip-flop stage.
// - The hold-enable goes to the enable/select input of the D flip-flop that freezes the displayed mic sample.
// - Sits directly upstream of that hold stage, in the same clock domain.
// - Also provides a clean level plus one-cycle press/release strobes for the mode-select logic.
// PARAMETERS
// - STABLE_CYCLES  1_000_000    consecutive sampled edges of the new level needed to accept a change (10 ms @ 100 MHz); legal 1..2^20
// - LONG_CYCLES    100_000_000  cycles after press_pulse before long_pulse fires (used only with BTN_LONG_PRESS_EN); legal 1..2^27
// PORTS
// - db_clock       in   1  system clock, rising edge
// - db_reset_n     in   1  asynchronous, active-low reset
// - btn_raw        in   1  raw, asynchronous, bouncing pushbutton; 1 = pressed
// - btn_level      out  1  debounced button level
// - press_pulse    out  1  one-cycle strobe on accepted press
// - release_pulse  out  1  one-cycle strobe on accepted release
// - hold_en        out  1  toggles on every accepted press; feeds the hold flip-flop's enable
// - long_pulse     out  1  one-cycle long-press strobe; port exists only with BTN_LONG_PRESS_EN
// BEHAVIOUR
// - Synchronizer: two flops, btn_raw -> s1 -> s2. Only s2 is used by the FSM.
// - Counter cnt: width $clog2(STABLE_CYCLES)+1.
// - All outputs are registered.
// - FSM states and transitions (one transition per db_clock edge):
//   - IDLE: btn_level=0. If s2=1: go to WAIT_HI, cnt<=0.
//   - WAIT_HI: if s2=0: go to IDLE (bounce rejected, no strobe).
//     Else if cnt==STABLE_CYCLES-1: go to PRESSED; btn_level<=1; press_pulse<=1; hold_en<=~hold_en.
//     Else cnt<=cnt+1.
//   - PRESSED: btn_level=1. If s2=0: go to WAIT_LO, cnt<=0.
//   - WAIT_LO: if s2=1: go to PRESSED (glitch rejected, no strobe).
//     Else if cnt==STABLE_CYCLES-1: go to IDLE; btn_level<=0; release_pulse<=1.
//     Else cnt<=cnt+1.
// - Latency: press_pulse is high in the cycle after the (STABLE_CYCLES+3)th consecutive edge at which btn_raw is sampled 1.
//   The first sampling edge counts as edge 1. Release has the same latency, with btn_raw sampled 0.
// - Strobes: press_pulse and release_pulse are high for exactly one cycle and are never high together.
// - Reset values: btn_level, press_pulse, release_pulse, hold_en, long_pulse, s1, s2 and cnt are all 0; state is IDLE.
// - Reset mid-operation: takes effect immediately, independent of db_clock. No strobe is emitted on reset or on reset release.
// - Button held through reset release: after release the normal press sequence runs and produces a fresh press_pulse.
// - No wrap-around: cnt never exceeds STABLE_CYCLES-1. The counter is cleared on every state entry.
// - hold_en changes only on an accepted press. Releases and rejected bounces leave it unchanged.
// CONFIGURATION
// - Macro: `BTN_LONG_PRESS_EN.
// - Defined:
//   - Adds output port long_pulse and a second counter lcnt of width $clog2(LONG_CYCLES)+1.
//   - lcnt is cleared on the edge that sets press_pulse and increments every cycle while in PRESSED or WAIT_LO.
//   - When lcnt==LONG_CYCLES-1: long_pulse<=1 for one cycle. It fires at most once per press; lcnt saturates afterwards.
//   - Entering IDLE clears lcnt.
// - Undefined: long_pulse port and lcnt are absent. All other behaviour is identical.
// TESTING
// - Bench parameters: STABLE_CYCLES=4, LONG_CYCLES=16, db_clock period 10 ns.
// 1. Reset: hold btn_raw=1 for 20 cycles, then pull db_reset_n low between edges.
//    -> btn_level, hold_en and all strobes go to 0 before the next edge.
//    -> After reset release, press_pulse fires on sampled edge 7.
// 2. Clean press: btn_raw=1 held 12 cycles from reset state.
//    -> press_pulse high for exactly one cycle after edge 7; btn_level=1 from then; hold_en 0->1.
// 3. Bounce rejection: btn_raw 1 for 3 cycles, 0 for 1, 1 for 2, then 0.
//    -> no press_pulse; btn_level and hold_en stay 0.
// 4. Release then re-press: after scenario 2, btn_raw=0 for 10 cycles, then 1 for 10 cycles.
//    -> release_pulse after the 7th sampled-0 edge; btn_level=0; hold_en stays 1.
//    -> The next press_pulse sets hold_en 1->0.
// 5. Glitch while pressed: in PRESSED, btn_raw=0 for 2 cycles then 1.
//    -> no release_pulse; btn_level stays 1 throughout.
// 6. Long press with BTN_LONG_PRESS_EN: btn_raw=1 held 40 cycles.
//    -> exactly one long_pulse, 16 cycles after press_pulse.
//    -> Same stimulus with the macro undefined compiles without the long_pulse port, and the other outputs are unchanged.

Source files
------------

// File: rtl/btn_hold_ctrl.sv
// Pushbutton debouncer producing a clean level, press/release strobes and the
// hold-enable toggle for the sample-hold stage. Optional long-press strobe: BTN_LONG_PRESS_EN.
module btn_hold_ctrl #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES   = 100_000_000
) (
  input  logic db_clock,
  input  logic db_reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_en
`ifdef BTN_LONG_PRESS_EN
  ,
  output logic long_pulse
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << 20)) begin : g_bad_stable
    $error("btn_hold_ctrl: STABLE_CYCLES outside 1..2^20");
  end
  if (LONG_CYCLES < 1 || LONG_CYCLES > (1 << 27)) begin : g_bad_long
    $error("btn_hold_ctrl: LONG_CYCLES outside 1..2^27");
  end

  logic             r_s1;
  logic             r_s2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_level;
  logic             r_press;
  logic             r_release;
  logic             r_hold;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press;
  logic             w_release;
  logic             w_level_nxt;

  // NOTE: the synchronizer flops are reset as well, so a stale pre-reset sample
  // can never reach the FSM after reset release.
  always_ff @(posedge db_clock or negedge db_reset_n) begin
    if (!db_reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make s1 -> s2 a real two-stage shift.
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_s2) begin
          w_state_nxt = ST_WAIT_HI;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!r_s2) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!r_s2) begin
          w_state_nxt = ST_WAIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (r_s2) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The debounced level is high exactly while the FSM sits on the pressed side.
  assign w_level_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_WAIT_LO);

  always_ff @(posedge db_clock or negedge db_reset_n) begin
    if (!db_reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_btn_level <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_hold      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_btn_level <= w_level_nxt;
      r_press     <= w_press;
      r_release   <= w_release;
      r_hold      <= r_hold ^ w_press;
    end
  end

  assign btn_level     = r_btn_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign hold_en       = r_hold;

`ifdef BTN_LONG_PRESS_EN
  localparam int LCNT_W = $clog2(LONG_CYCLES) + 1;
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LCNT_SAT  = LCNT_W'(LONG_CYCLES);
  localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);

  logic [LCNT_W-1:0] r_lcnt;
  logic              r_long;
  logic              w_lcnt_active;

  assign w_lcnt_active = (r_state == ST_PRESSED) || (r_state == ST_WAIT_LO);

  // lcnt parks at LONG_CYCLES after firing, so the strobe fires once per press.
  always_ff @(posedge db_clock or negedge db_reset_n) begin
    if (!db_reset_n) begin
      r_lcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= w_lcnt_active && (r_lcnt == LCNT_LAST);
      if (w_press || (w_state_nxt == ST_IDLE)) begin
        r_lcnt <= '0;
      end else if (w_lcnt_active && (r_lcnt != LCNT_SAT)) begin
        r_lcnt <= r_lcnt + LCNT_ONE;
      end
    end
  end

  assign long_pulse = r_long;
`endif

endmodule
